// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and constants for the PLL lock controller
package pll_ctrl_pkg;

  typedef enum logic [1:0] {S_RST, S_WAIT, S_STAB, S_RUN} pll_state_t;

  localparam int RELOCK_CNT_W       = 8;
  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic 2-flop synchronizer with async active-low reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset sequencer and lock supervisor
// Optional wait-for-lock watchdog: define PLL_LOCK_CTRL_TIMEOUT_EN.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    relock_req,
  output logic                    pll_rst,
  output logic                    clk_ok,
  output logic                    lock_lost,
  output logic [RELOCK_CNT_W-1:0] relock_cnt,
  output logic                    lock_timeout
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  pll_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;

  sync2 #(.W(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // A software relock outranks every other transition; in S_RST it is ignored.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      clk_ok     <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
      lock_timeout <= 1'b0;
`endif
    end else begin
      lock_lost <= 1'b0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
      lock_timeout <= 1'b0;
`endif
      if (relock_req && state != S_RST) begin
        state   <= S_RST;
        cnt     <= '0;
        pll_rst <= 1'b1;
        clk_ok  <= 1'b0;
      end else begin
        case (state)
          S_RST: begin
            if (cnt == RST_LAST) begin
              state   <= S_WAIT;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (locked_s) begin
              state <= S_STAB;
              cnt   <= '0;
            end
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
            else if (cnt == TO_LAST) begin
              state        <= S_RST;
              cnt          <= '0;
              pll_rst      <= 1'b1;
              lock_timeout <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`endif
          end
          S_STAB: begin
            if (!locked_s) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else if (cnt == STAB_LAST) begin
              state  <= S_RUN;
              cnt    <= '0;
              clk_ok <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_RUN: begin
            if (!locked_s) begin
              state     <= S_RST;
              cnt       <= '0;
              pll_rst   <= 1'b1;
              clk_ok    <= 1'b0;
              lock_lost <= 1'b1;
              if (relock_cnt != '1) relock_cnt <= relock_cnt + 1'b1;
            end
          end
          default: begin
            state   <= S_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            clk_ok  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef PLL_LOCK_CTRL_TIMEOUT_EN
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - scoreboard bench for pll_lock_ctrl (RST=4, STABLE=8, TIMEOUT=32)
module tb_pll_lock_ctrl;

  typedef enum int {EV_RST_RISE, EV_RST_FALL, EV_OK_RISE, EV_OK_FALL, EV_LOST, EV_TMO} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       cnt;
  } ev_t;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       clk_ok;
  logic       lock_lost;
  logic [7:0] relock_cnt;
  logic       lock_timeout;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  m_cnt = 0;

  logic p_rst = 1'b1, p_ok = 1'b0, p_lost = 1'b0, p_tmo = 1'b0;

  pll_lock_ctrl #(
    .RST_CYCLES     (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .clk_ok       (clk_ok),
    .lock_lost    (lock_lost),
    .relock_cnt   (relock_cnt),
    .lock_timeout (lock_timeout)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cnt != int'(relock_cnt)) begin
        fails++;
        $display("FAIL event: got kind %0d cycle %0d relock_cnt %0d, expected kind %0d cycle %0d relock_cnt %0d",
                 k, cyc, relock_cnt, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  // Monitor: every output change is an event that must match the scoreboard head.
  always @(negedge refclk) begin
    if (pll_rst !== p_rst) got(pll_rst ? EV_RST_RISE : EV_RST_FALL);
    if (clk_ok !== p_ok)   got(clk_ok ? EV_OK_RISE : EV_OK_FALL);
    if (lock_lost && !p_lost)  got(EV_LOST);
    if (lock_timeout && !p_tmo) got(EV_TMO);
    if (p_lost) chk("lock_lost_width", int'(lock_lost), 0);
    if (p_tmo)  chk("lock_timeout_width", int'(lock_timeout), 0);
    p_rst  = pll_rst;
    p_ok   = clk_ok;
    p_lost = lock_lost;
    p_tmo  = lock_timeout;
  end

  task automatic power_up();
    rst_n = 1'b1;
    push(EV_RST_FALL, cyc + 4);
    repeat (10) @(negedge refclk);
    pll_locked = 1'b1;
    push(EV_OK_RISE, cyc + 11);
    repeat (12) @(negedge refclk);
    chk("powerup_relock_cnt", int'(relock_cnt), m_cnt);
  endtask

  task automatic lose_lock();
    int c;
    c = cyc;
    pll_locked = 1'b0;
    if (m_cnt < 255) m_cnt++;
    push(EV_RST_RISE, c + 3);
    push(EV_OK_FALL, c + 3);
    push(EV_LOST, c + 3);
    push(EV_RST_FALL, c + 7);
    repeat (8) @(negedge refclk);
    pll_locked = 1'b1;
    push(EV_OK_RISE, cyc + 11);
    repeat (12) @(negedge refclk);
  endtask

  task automatic relock_and_glitch();
    int c;
    c = cyc;
    relock_req = 1'b1;
    push(EV_RST_RISE, c + 1);
    push(EV_OK_FALL, c + 1);
    @(negedge refclk);
    relock_req = 1'b0;
    @(negedge refclk);
    relock_req = 1'b1;
    push(EV_RST_FALL, c + 5);
    @(negedge refclk);
    relock_req = 1'b0;
    repeat (7) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    push(EV_OK_RISE, cyc + 11);
    repeat (12) @(negedge refclk);
    chk("relock_cnt_after_sw_relock", int'(relock_cnt), m_cnt);
    chk("pll_rst_after_glitch", int'(pll_rst), 0);
  endtask

  task automatic mid_reset();
    @(negedge refclk);
    #3;
    m_cnt = 0;
    push(EV_RST_RISE, cyc + 1);
    push(EV_OK_FALL, cyc + 1);
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    #1;
    chk("async_pll_rst", int'(pll_rst), 1);
    chk("async_clk_ok", int'(clk_ok), 0);
    chk("async_relock_cnt", int'(relock_cnt), 0);
    chk("async_lock_lost", int'(lock_lost), 0);
    repeat (3) @(negedge refclk);
  endtask

  task automatic timeout_phase();
    int c;
    c = cyc;
    pll_locked = 1'b0;
    if (m_cnt < 255) m_cnt++;
    push(EV_RST_RISE, c + 3);
    push(EV_OK_FALL, c + 3);
    push(EV_LOST, c + 3);
    push(EV_RST_FALL, c + 7);
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      push(EV_RST_RISE, c + 39 + 36 * k);
      push(EV_TMO, c + 39 + 36 * k);
      push(EV_RST_FALL, c + 43 + 36 * k);
    end
    repeat (120) @(negedge refclk);
`else
    repeat (1000) @(negedge refclk);
    chk("no_timeout_pulse", int'(lock_timeout), 0);
`endif
    chk("pll_rst_low_waiting", int'(pll_rst), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_clk_ok", int'(clk_ok), 0);
    chk("reset_relock_cnt", int'(relock_cnt), 0);
    chk("reset_lock_lost", int'(lock_lost), 0);
    chk("reset_lock_timeout", int'(lock_timeout), 0);

    power_up();
    relock_and_glitch();
    repeat (3) lose_lock();
    chk("relock_cnt_3", int'(relock_cnt), 3);
    mid_reset();
    power_up();
    repeat (300) lose_lock();
    chk("relock_cnt_saturated", int'(relock_cnt), 255);
    timeout_phase();

    repeat (3) @(negedge refclk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
